// File: rtl/buffer_bank_reader_pkg.sv
// Shared types and constants for the frame-buffer bank reader.
package buffer_bank_reader_pkg;

    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Width of a field that counts to n-1, never narrower than one bit.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/buffer_bank_reader_read_skid_fifo.sv
// Four-entry output FIFO for tagged read words; occupancy drives read throttling.
module read_skid_fifo
    import buffer_bank_reader_pkg::*;
#(
    parameter  int DATA_W = 35,
    localparam int PTR_W  = safe_clog2(FIFO_DEPTH),
    localparam int CNT_W  = safe_clog2(FIFO_DEPTH + 1)
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_push,
    input  logic [DATA_W-1:0] I_push_data,
    input  logic              I_pop,
    output logic              O_valid,
    output logic [DATA_W-1:0] O_data,
    output logic [CNT_W-1:0]  O_count
);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_pop;

    assign w_pop = I_pop && (r_count != '0);

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (I_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({I_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is left unreset; the head word is masked to zero while empty,
    // so stale contents are never visible and the array maps cleanly onto RAM.
    always_ff @(posedge I_clk) begin
        if (I_push) r_mem[r_wr_ptr] <= I_push_data;
    end

    assign O_valid = (r_count != '0);
    assign O_data  = O_valid ? r_mem[r_rd_ptr] : '0;
    assign O_count = r_count;

endmodule

// File: rtl/buffer_bank_reader.sv
// Frame-buffer read engine: locks the newest completed bank and streams it out per SPI channel.
// Optional repeat-last-frame behaviour is enabled by defining BUFFER_BANK_READER_REPEAT_EN.
module buffer_bank_reader
    import buffer_bank_reader_pkg::*;
#(
    parameter  int BLOCK_WIDTH       = 32,
    parameter  int BLOCK_DEPTH       = 480,
    parameter  int BANK_COUNT        = 3,
    parameter  int BLOCK_COUNT       = 4,
    parameter  int SPI_CHANNEL_COUNT = 3,
    localparam int BANK_W = safe_clog2(BANK_COUNT),
    localparam int BLK_W  = safe_clog2(BLOCK_COUNT),
    localparam int ADDR_W = safe_clog2(BLOCK_DEPTH),
    localparam int CH_W   = safe_clog2(SPI_CHANNEL_COUNT)
) (
    input  logic                   I_clk,
    input  logic                   I_rst,
    input  logic                   I_bank_done,
    input  logic [BANK_W-1:0]      I_bank_done_id,
    input  logic                   I_frame_start,
    output logic                   O_busy,
    output logic [BANK_W-1:0]      O_read_bank,
    output logic                   O_bram_rd_en,
    output logic [BLK_W-1:0]       O_bram_block,
    output logic [ADDR_W-1:0]      O_bram_addr,
    input  logic [BLOCK_WIDTH-1:0] I_bram_data,
    output logic [BLOCK_WIDTH-1:0] O_data,
    output logic [CH_W-1:0]        O_channel,
    output logic                   O_last,
    output logic                   O_valid,
    input  logic                   I_ready,
    output logic                   O_frame_done,
    output logic                   O_frame_skipped
);

    localparam int FIFO_W = BLOCK_WIDTH + CH_W + 1;
    localparam int CNT_W  = safe_clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOCK_DEPTH - 1);
    localparam logic [BLK_W-1:0]  LAST_BLK  = BLK_W'(BLOCK_COUNT - 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(SPI_CHANNEL_COUNT - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [BANK_W-1:0]   r_latest;
    logic [BANK_W-1:0]   r_read_bank;
    logic                r_have_new;
    logic [BLK_W-1:0]    r_blk;
    logic [ADDR_W-1:0]   r_addr;
    logic [CH_W-1:0]     r_ch;
    logic                r_inflight;
    logic [CH_W-1:0]     r_inflight_ch;
    logic                r_inflight_last;
    logic                r_frame_done;
    logic                r_frame_skipped;

    logic                w_can_repeat;
    logic                w_idle_start;
    logic                w_start_ok;
    logic                w_refuse;
    logic                w_busy;
    logic                w_rd_en;
    logic                w_final_rd;
    logic                w_fire_last;
    logic [CNT_W-1:0]    w_pending;
    logic                w_fifo_valid;
    logic [FIFO_W-1:0]   w_fifo_data;
    logic [CNT_W-1:0]    w_fifo_count;

`ifdef BUFFER_BANK_READER_REPEAT_EN
    logic r_ever_done;

    always_ff @(posedge I_clk) begin
        if (I_rst)            r_ever_done <= 1'b0;
        else if (I_bank_done) r_ever_done <= 1'b1;
    end

    assign w_can_repeat = r_ever_done;
`else
    assign w_can_repeat = 1'b0;
`endif

    assign w_idle_start = I_frame_start && (r_state == ST_IDLE);
    assign w_start_ok   = w_idle_start && (r_have_new || w_can_repeat);
    assign w_refuse     = w_idle_start && !w_start_ok;
    assign w_pending    = w_fifo_count + CNT_W'(r_inflight);
    assign w_final_rd   = w_rd_en && (r_addr == LAST_ADDR) && (r_blk == LAST_BLK);
    assign w_fire_last  = w_fifo_valid && I_ready && w_fifo_data[0];

    always_ff @(posedge I_clk) begin
        if (I_rst) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_ok)  w_next_state = ST_FETCH;
            ST_FETCH: if (w_final_rd)  w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_fire_last) w_next_state = ST_IDLE;
            default:                   w_next_state = ST_IDLE;
        endcase
    end

    // Reads stop while buffered plus in-flight words would overrun the FIFO.
    always_comb begin
        w_busy  = (r_state != ST_IDLE);
        w_rd_en = (r_state == ST_FETCH) && (w_pending < CNT_W'(FIFO_DEPTH));
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_latest        <= '0;
            r_have_new      <= 1'b0;
            r_read_bank     <= '0;
            r_blk           <= '0;
            r_addr          <= '0;
            r_ch            <= '0;
            r_inflight      <= 1'b0;
            r_inflight_ch   <= '0;
            r_inflight_last <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_skipped <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_have_new  <= 1'b0;
                r_read_bank <= r_latest;
                r_blk       <= '0;
                r_addr      <= '0;
                r_ch        <= '0;
            end
            // A completion in the same cycle as a start is kept for the next frame.
            if (I_bank_done) begin
                r_latest   <= I_bank_done_id;
                r_have_new <= 1'b1;
            end
            if (w_rd_en) begin
                if (r_blk == LAST_BLK) begin
                    r_blk  <= '0;
                    r_ch   <= '0;
                    r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_W'(1);
                end else begin
                    r_blk <= r_blk + BLK_W'(1);
                    r_ch  <= (r_ch == LAST_CH) ? '0 : r_ch + CH_W'(1);
                end
            end
            r_inflight      <= w_rd_en;
            r_inflight_ch   <= r_ch;
            r_inflight_last <= w_final_rd;
            r_frame_done    <= (r_state == ST_DRAIN) && w_fire_last;
            r_frame_skipped <= w_refuse;
        end
    end

    read_skid_fifo #(
        .DATA_W (FIFO_W)
    ) u_fifo (
        .I_clk       (I_clk),
        .I_rst       (I_rst),
        .I_push      (r_inflight),
        .I_push_data ({I_bram_data, r_inflight_ch, r_inflight_last}),
        .I_pop       (I_ready),
        .O_valid     (w_fifo_valid),
        .O_data      (w_fifo_data),
        .O_count     (w_fifo_count)
    );

    assign O_busy          = w_busy;
    assign O_read_bank     = w_busy ? r_read_bank : '0;
    assign O_bram_rd_en    = w_rd_en;
    assign O_bram_block    = r_blk;
    assign O_bram_addr     = r_addr;
    assign O_valid         = w_fifo_valid;
    assign O_data          = w_fifo_data[FIFO_W-1 -: BLOCK_WIDTH];
    assign O_channel       = w_fifo_data[CH_W:1];
    assign O_last          = w_fifo_data[0];
    assign O_frame_done    = r_frame_done;
    assign O_frame_skipped = r_frame_skipped;

endmodule

// File: tb/tb_buffer_bank_reader.sv
// Directed bench for buffer_bank_reader: default geometry plus a 5-block / 2-channel instance.
module tb_buffer_bank_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        rst, bank_done, frame_start, ready;
    logic [1:0]  bank_done_id;
    logic        busy, rd_en, last, valid, frame_done, frame_skipped;
    logic [1:0]  read_bank, blk, ch;
    logic [8:0]  addr;
    logic [31:0] bram_data, data;

    logic        s_bank_done, s_frame_start, s_ready;
    logic [1:0]  s_bank_done_id, s_read_bank;
    logic        s_busy, s_rd_en, s_last, s_valid, s_frame_done, s_frame_skipped;
    logic [2:0]  s_blk;
    logic [1:0]  s_addr;
    logic [0:0]  s_ch;
    logic [31:0] s_bram_data, s_data;

    buffer_bank_reader dut (
        .I_clk(clk), .I_rst(rst), .I_bank_done(bank_done), .I_bank_done_id(bank_done_id),
        .I_frame_start(frame_start), .O_busy(busy), .O_read_bank(read_bank),
        .O_bram_rd_en(rd_en), .O_bram_block(blk), .O_bram_addr(addr), .I_bram_data(bram_data),
        .O_data(data), .O_channel(ch), .O_last(last), .O_valid(valid), .I_ready(ready),
        .O_frame_done(frame_done), .O_frame_skipped(frame_skipped)
    );

    buffer_bank_reader #(
        .BLOCK_DEPTH(3), .BLOCK_COUNT(5), .SPI_CHANNEL_COUNT(2)
    ) dut_s (
        .I_clk(clk), .I_rst(rst), .I_bank_done(s_bank_done), .I_bank_done_id(s_bank_done_id),
        .I_frame_start(s_frame_start), .O_busy(s_busy), .O_read_bank(s_read_bank),
        .O_bram_rd_en(s_rd_en), .O_bram_block(s_blk), .O_bram_addr(s_addr),
        .I_bram_data(s_bram_data), .O_data(s_data), .O_channel(s_ch), .O_last(s_last),
        .O_valid(s_valid), .I_ready(s_ready), .O_frame_done(s_frame_done),
        .O_frame_skipped(s_frame_skipped)
    );

    // Each BRAM word encodes its bank, block and address.
    function automatic logic [31:0] pat(input int bank, input int b, input int a);
        return {4'hC, 4'(bank), 8'(b), 16'(a)};
    endfunction

    // Expected {data, channel, last} for word k of a default-geometry frame.
    function automatic logic [34:0] exp_word(input int bank, input int k);
        int a, b;
        a = k / 4;
        b = k % 4;
        return {pat(bank, b, a), 2'(b % 3), k == 1919};
    endfunction

    always @(posedge clk) begin
        if (rd_en)   bram_data   <= pat(int'(read_bank), int'(blk), int'(addr));
        if (s_rd_en) s_bram_data <= pat(int'(s_read_bank), int'(s_blk), int'(s_addr));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done(input int id);
        bank_done    = 1'b1;
        bank_done_id = 2'(id);
        step();
        bank_done    = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".outs"},
              64'({busy, read_bank, rd_en, blk, addr, data, ch, last, valid, frame_done, frame_skipped}),
              64'(0));
    endtask

    task automatic check_refused(input string tag);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check({tag, ".skip"}, 64'({frame_skipped, busy, rd_en}), 64'(3'b100));
        step();
        check({tag, ".skip_end"}, 64'({frame_skipped, busy, rd_en}), 64'(3'b000));
    endtask

    // Start a frame, stream it out, optionally inject bank_done id 2 at word inject_at.
    task automatic run_frame(input string tag, input int bank, input bit toggle, input int inject_at);
        int k, first_v, lat, start_cyc;
        bit stalled, done, injected;
        logic [34:0] held;
        k = 0; first_v = -1; lat = -1; stalled = 0; done = 0; injected = 0; held = '0;
        frame_start = 1'b1;
        start_cyc   = cyc;
        step();
        frame_start = 1'b0;
        check({tag, ".first_rd"}, 64'({busy, read_bank, rd_en, blk, addr}), 64'({1'b1, 2'(bank), 1'b1, 2'd0, 9'd0}));
        for (int n = 0; n < 6000 && !done; n++) begin
            ready     = toggle ? (n % 2 == 0) : 1'b1;
            bank_done = 1'b0;
            if (inject_at >= 0 && !injected && k == inject_at) begin
                bank_done    = 1'b1;
                bank_done_id = 2'd2;
                injected     = 1;
            end
            if (stalled) check({tag, ".hold"}, 64'({valid, data, ch, last}), 64'({1'b1, held}));
            if (valid && first_v < 0) first_v = cyc - start_cyc;
            if (frame_done) begin
                done = 1;
                lat  = cyc - start_cyc;
            end else begin
                if (valid && ready) begin
                    check({tag, ".word"}, 64'({data, ch, last}), 64'(exp_word(bank, k)));
                    k++;
                    stalled = 0;
                end else if (valid) begin
                    stalled = 1;
                    held    = {data, ch, last};
                end else begin
                    stalled = 0;
                end
                step();
            end
        end
        bank_done = 1'b0;
        ready     = 1'b1;
        check({tag, ".done_seen"}, 64'(done), 64'(1));
        check({tag, ".word_count"}, 64'(k), 64'(1920));
        check({tag, ".first_valid"}, 64'(first_v), 64'(3));
        check({tag, ".at_done"}, 64'({valid, busy, read_bank}), 64'(0));
        if (!toggle) check({tag, ".latency"}, 64'(lat), 64'(1923));
    endtask

    initial begin
        int cnt, k, lat, sc;
        bit done;
        rst = 1'b1; bank_done = 1'b0; bank_done_id = '0; frame_start = 1'b0; ready = 1'b1;
        s_bank_done = 1'b0; s_bank_done_id = '0; s_frame_start = 1'b0; s_ready = 1'b1;
        repeat (3) step();
        check_quiet("reset");
        rst = 1'b0;
        step();
        check_quiet("idle");
        check_refused("no_bank");

        pulse_done(1);
        run_frame("f1", 1, 1'b0, -1);
        pulse_done(1);
        run_frame("f2_toggle", 1, 1'b1, -1);

`ifdef BUFFER_BANK_READER_REPEAT_EN
        run_frame("repeat", 1, 1'b0, -1);
`else
        check_refused("stale");
`endif

        pulse_done(1);
        run_frame("f4_inject", 1, 1'b0, 500);
        run_frame("f5_bank2", 2, 1'b0, -1);

        // Abort mid-frame with reset after 500 accepted words.
        pulse_done(0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        cnt = 0;
        for (int n = 0; n < 3000 && cnt < 500; n++) begin
            if (valid) cnt++;
            if (cnt < 500) step();
        end
        check("abort.reached", 64'(cnt), 64'(500));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_quiet("abort");
        for (int n = 0; n < 6; n++) begin
            step();
            check("abort.no_done", 64'({frame_done, valid, busy}), 64'(0));
        end
        check_refused("abort_tracker");
        pulse_done(2);
        run_frame("f6_after_abort", 2, 1'b0, -1);

        // Small geometry: 5 blocks, 2 channels, depth 3.
        s_bank_done    = 1'b1;
        s_bank_done_id = 2'd1;
        step();
        s_bank_done   = 1'b0;
        s_frame_start = 1'b1;
        sc = cyc;
        step();
        s_frame_start = 1'b0;
        k = 0; done = 0; lat = -1;
        for (int n = 0; n < 200 && !done; n++) begin
            if (s_frame_done) begin
                done = 1;
                lat  = cyc - sc;
            end else begin
                if (s_valid) begin
                    check("small.word", 64'({s_data, s_ch, s_last}),
                          64'({pat(1, k % 5, k / 5), 1'((k % 5) % 2), k == 14}));
                    k++;
                end
                step();
            end
        end
        check("small.done_seen", 64'(done), 64'(1));
        check("small.word_count", 64'(k), 64'(15));
        check("small.latency", 64'(lat), 64'(18));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
